// File: rtl/ifns_decoder_29.sv
// Bit-serial decoder for 29-bit Fibonacci-weighted codewords.
// Weights W[i] come from a running (prev, cur) pair, one codeword bit per cycle, LSB first.
module ifns_decoder_29 (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [28:0] codein,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] dataout,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state;
  logic [28:0] shreg;
  logic [21:0] acc;
  logic [21:0] cur;
  logic [21:0] prev;
  logic [4:0]  count;
  logic [21:0] acc_next;

  assign acc_next  = acc + (shreg[0] ? cur : 22'd0);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The result registers are loaded from acc_next on the last bit so DONE presents the full sum.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      acc     <= '0;
      cur     <= '0;
      prev    <= '0;
      count   <= '0;
      dataout <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= codein;
            acc   <= '0;
            cur   <= 22'd1;
            prev  <= 22'd1;
            count <= 5'd29;
            state <= ACC;
          end
        end
        ACC: begin
          acc   <= acc_next;
          shreg <= shreg >> 1;
          prev  <= cur;
          cur   <= cur + prev;
          count <= count - 5'd1;
          if (count == 5'd1) begin
            dataout <= acc_next[19:0];
            ovf     <= |acc_next[21:20];
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifns_decoder_29.sv
// Directed self-checking bench for ifns_decoder_29: latency, handshakes, overflow, reset abort, backpressure.
module tb_ifns_decoder_29;

  logic        clock;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] codein;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] dataout;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;

  ifns_decoder_29 dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codein(codein), .out_valid(out_valid), .out_ready(out_ready),
    .dataout(dataout), .ovf(ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Presents a codeword for one rising edge, then scrambles codein while the decoder is busy.
  task automatic applyStimulus(input logic [28:0] code);
    @(negedge clock);
    in_valid = 1'b1;
    codein   = code;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    codein   = 29'($urandom());
    checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Called on the negedge just after the accept edge; returns negedges until out_valid is seen.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clock);
      lat++;
      if (!out_valid) codein = 29'($urandom());
    end
  endtask

  function automatic int refSum(input logic [28:0] c);
    int w_a, w_b, t, s;
    w_a = 1; w_b = 2; s = 0;
    for (int i = 0; i < 29; i++) begin
      if (c[i]) s += w_a;
      t = w_a + w_b; w_a = w_b; w_b = t;
    end
    return s;
  endfunction

  initial begin
    int lat;
    logic [28:0] code;
    logic [19:0] held;
    int s;

    rst_n = 1'b0; in_valid = 1'b0; codein = '0; out_ready = 1'b1;
    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_dataout", 32'(dataout), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clock); rst_n = 1'b1;

    // 29'b10101 -> 1+3+8 = 12, one-cycle pulse with out_ready held
    applyStimulus(29'b10101);
    waitResult(lat);
    checkOutput("latency_12", 32'(lat), 32'd29);
    checkOutput("data_12", 32'(dataout), 32'd12);
    checkOutput("ovf_12", 32'(ovf), 32'd0);
    @(negedge clock);
    checkOutput("pulse_out_valid", 32'(out_valid), 32'd0);
    checkOutput("pulse_in_ready", 32'(in_ready), 32'd1);

    // all ones -> 2178307 = 0x213D03
    applyStimulus(29'h1FFFFFFF);
    waitResult(lat);
    checkOutput("latency_max", 32'(lat), 32'd29);
    checkOutput("data_max", 32'(dataout), 32'h13D03);
    checkOutput("ovf_max", 32'(ovf), 32'd1);
    @(negedge clock);

    // bits 1..20 -> 28655
    applyStimulus(29'h000FFFFF);
    waitResult(lat);
    checkOutput("data_20ones", 32'(dataout), 32'd28655);
    checkOutput("ovf_20ones", 32'(ovf), 32'd0);
    @(negedge clock);

    // zero codeword takes the full latency
    applyStimulus(29'h0);
    waitResult(lat);
    checkOutput("latency_zero", 32'(lat), 32'd29);
    checkOutput("data_zero", 32'(dataout), 32'd0);
    checkOutput("ovf_zero", 32'(ovf), 32'd0);
    @(negedge clock);

    // top bit alone -> W[29] = 832040, no overflow
    applyStimulus(29'h10000000);
    waitResult(lat);
    checkOutput("data_top", 32'(dataout), 32'd832040);
    checkOutput("ovf_top", 32'(ovf), 32'd0);
    @(negedge clock);

    // backpressure: hold for 10 cycles while a second codeword is offered
    out_ready = 1'b0;
    applyStimulus(29'b11001);
    waitResult(lat);
    checkOutput("bp_data_first", 32'(dataout), 32'd14);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      codein   = 29'h1FFFFFFF;
      @(negedge clock);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_dataout", 32'(dataout), 32'd14);
      checkOutput("bp_ovf", 32'(ovf), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clock);
    checkOutput("bp_no_accept", 32'(in_ready), 32'd1);

    // reset in the middle of accumulation abandons the codeword
    applyStimulus(29'h1FFFFFFF);
    repeat (14) @(negedge clock);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_dataout", 32'(dataout), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clock); rst_n = 1'b1;
    repeat (35) @(negedge clock);
    checkOutput("abort_no_valid", 32'(out_valid), 32'd0);
    applyStimulus(29'b1000000);
    waitResult(lat);
    checkOutput("after_abort_data", 32'(dataout), 32'd21);
    @(negedge clock);

    // random codewords with random backpressure
    for (int n = 0; n < 8; n++) begin
      code = 29'($urandom());
      s = refSum(code);
      out_ready = 1'b0;
      applyStimulus(code);
      waitResult(lat);
      checkOutput("rnd_latency", 32'(lat), 32'd29);
      checkOutput("rnd_data", 32'(dataout), 32'(s[19:0]));
      checkOutput("rnd_ovf", 32'(ovf), 32'(s >= (1 << 20)));
      held = dataout;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        checkOutput("rnd_hold", 32'(dataout), 32'(held));
      end
      out_ready = 1'b1;
      @(negedge clock);
      checkOutput("rnd_consumed", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
